// File: rtl/vermibus_memory_responder.sv
// vermibus_memory_responder: responder end of the Vermibus read/write protocol.
// Word-organised RAM with a programmable number of wait states before the
// one-cycle ready pulse. Reads return the pre-write contents of the word.
// Optional feature macro: VERMIBUS_RESPONDER_ERROR_EN enables the address
// range check and the sticky error flag. Without it, addresses alias modulo
// SIZE and error is tied low.
module vermibus_memory_responder #(
    parameter int unsigned SIZE         = 1024,
    parameter int unsigned LATENCY      = 0,
    parameter logic [31:0] ADDRESS_BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [31:0] address,
    input  logic [3:0]  wstrobe,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        error
);

    localparam int unsigned IDXW = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              commit_s;
    logic [31:0]       mem_q [SIZE];
    logic [31:0]       rdata_q;
    logic [31:0]       offset_s;
    logic [IDXW-1:0]   index_s;
    logic              in_range_s;
    logic              unused_s;

    // Merge the strobed byte lanes of new data into the old word.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign offset_s = address - ADDRESS_BASE;
    assign index_s  = offset_s[IDXW+1:2];
    // Byte-offset bits and (without range check) upper bits carry no meaning.
    assign unused_s = ^offset_s;

`ifdef VERMIBUS_RESPONDER_ERROR_EN
    assign in_range_s = ((offset_s >> (IDXW + 2)) == 32'd0);
`else
    assign in_range_s = 1'b1;
`endif

    // Next-state logic: request acceptance, wait countdown, abort and commit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        commit_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid) begin
                    if (LATENCY > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end else begin
                        state_d  = ST_RESPOND;
                        commit_s = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!valid) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d  = ST_RESPOND;
                    commit_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // FSM state and wait counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Read data captured at commit (pre-write contents); held until next commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= 32'h0000_0000;
        end else if (commit_s) begin
            rdata_q <= in_range_s ? mem_q[index_s] : 32'h0000_0000;
        end
    end

    // Storage array: not reset; a write lands only at a commit outside reset.
    always_ff @(posedge clk) begin
        if (!reset && commit_s && in_range_s) begin
            mem_q[index_s] <= merge_lanes(mem_q[index_s], wdata, wstrobe);
        end
    end

`ifdef VERMIBUS_RESPONDER_ERROR_EN
    logic error_q;

    // Sticky out-of-range flag, set at the commit of an out-of-range access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error_q <= 1'b0;
        end else if (commit_s && !in_range_s) begin
            error_q <= 1'b1;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign rdata = rdata_q;
    assign ready = (state_q == ST_RESPOND);

endmodule

// File: tb/tb_vermibus_memory_responder.sv
// Scoreboard bench for vermibus_memory_responder: the driver issues requests
// and pushes expected responses (from a byte-level memory model) into a queue;
// a monitor on the falling edge pops and compares on every ready pulse and
// checks that rdata/error hold between pulses.
module tb_vermibus_memory_responder;

    localparam int unsigned SIZE = 64;
    localparam int unsigned LAT  = 3;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0;
    logic [31:0] address = 32'h0;
    logic [3:0]  wstrobe = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        ready;
    logic        error;

    vermibus_memory_responder #(
        .SIZE(SIZE), .LATENCY(LAT), .ADDRESS_BASE(BASE)
    ) dut (
        .clk(clk), .reset(reset), .valid(valid), .address(address),
        .wstrobe(wstrobe), .wdata(wdata), .rdata(rdata), .ready(ready),
        .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] rd;
        logic [31:0] mask;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] model_mem [SIZE];
    logic [31:0] known [SIZE];
    logic        err_model = 1'b0;
    logic [31:0] hold_rd = 32'h0;
    logic [31:0] hold_mask = 32'hFFFF_FFFF;
    logic        hold_err = 1'b0;
    logic [31:0] last_rd = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok,
                         input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every ready pulse against the scoreboard, check hold otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            hold_rd   = 32'h0;
            hold_mask = 32'hFFFF_FFFF;
            hold_err  = 1'b0;
        end else if (ready) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", 1'b0, 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("ready_cycle", cyc == e.cyc, 32'(cyc), 32'(e.cyc));
                check("rdata", (rdata & e.mask) == (e.rd & e.mask), rdata, e.rd);
                check("error", error == e.err, 32'(error), 32'(e.err));
                hold_rd   = e.rd;
                hold_mask = e.mask;
                hold_err  = e.err;
                last_rd   = rdata;
            end
        end else begin
            check("rdata_hold", (rdata & hold_mask) == (hold_rd & hold_mask), rdata, hold_rd);
            check("error_hold", error == hold_err, 32'(error), 32'(hold_err));
        end
    end

    // Issue one access (called just after a rising edge); keep=1 holds valid for back-to-back.
    task automatic access(input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, input bit keep);
        exp_t        e;
        logic [31:0] rel;
        int          idx;
        bit          in_range;
        bit          got;
        // valid still high means the DUT is in RESPOND now and re-samples one edge later
        e.cyc = (valid ? cyc + 2 : cyc + 1) + int'(LAT);
        address = a;
        wstrobe = s;
        wdata   = d;
        valid   = 1'b1;
        rel = a - BASE;
        idx = int'((rel / 32'd4) % SIZE);
`ifdef VERMIBUS_RESPONDER_ERROR_EN
        in_range = (longint'(a) >= longint'(BASE)) &&
                   (longint'(a) < longint'(BASE) + 4 * longint'(SIZE));
`else
        in_range = 1'b1;
`endif
        if (in_range) begin
            e.rd   = model_mem[idx];
            e.mask = known[idx];
            for (int i = 0; i < 4; i++) begin
                if (s[i]) begin
                    model_mem[idx][8*i +: 8] = d[8*i +: 8];
                    known[idx][8*i +: 8]     = 8'hFF;
                end
            end
        end else begin
            e.rd      = 32'h0;
            e.mask    = 32'hFFFF_FFFF;
            err_model = 1'b1;
        end
        e.err = err_model;
        sb.push_back(e);
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(posedge clk);
            #1;
            got = ready;
        end
        if (!got) begin
            check("ready_timeout", 1'b0, a, 32'h0);
            sb.delete();
            valid = 1'b0;
        end
        if (!keep) begin
            valid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < SIZE; i++) begin
            model_mem[i] = 32'h0;
            known[i]     = 32'h0;
        end
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        check("reset_ready", ready == 1'b0, 32'(ready), 32'h0);
        check("reset_rdata", rdata == 32'h0, rdata, 32'h0);
        check("reset_error", error == 1'b0, 32'(error), 32'h0);

        // first read of index 0: timing only, contents unknown
        access(32'h0000_0000, 4'h0, 32'h0, 1'b0);

        // byte-lane merge, pre-write read data
        access(32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 1'b0);
        access(32'h0000_0010, 4'h2, 32'h0000_AA00, 1'b0);
        check("prewrite_rdata", last_rd == 32'hDEAD_BEEF, last_rd, 32'hDEAD_BEEF);
        access(32'h0000_0010, 4'h0, 32'h0, 1'b0);
        check("merge_rdata", last_rd == 32'hDEAD_AAEF, last_rd, 32'hDEAD_AAEF);

        // back-to-back reads with valid held across ready
        access(32'h0000_0020, 4'hF, 32'h1111_2222, 1'b0);
        access(32'h0000_0024, 4'hF, 32'h3333_4444, 1'b0);
        access(32'h0000_0020, 4'h0, 32'h0, 1'b1);
        access(32'h0000_0024, 4'h0, 32'h0, 1'b0);
        check("b2b_second", last_rd == 32'h3333_4444, last_rd, 32'h3333_4444);

        // reset during WAIT of a write: dropped, nothing committed
        address = 32'h0000_0010;
        wstrobe = 4'hF;
        wdata   = 32'h1234_5678;
        valid   = 1'b1;
        idle(2);
        reset     = 1'b1;
        valid     = 1'b0;
        err_model = 1'b0;
        idle(1);
        reset = 1'b0;
        check("abort_ready", ready == 1'b0, 32'(ready), 32'h0);
        check("abort_rdata", rdata == 32'h0, rdata, 32'h0);
        idle(2);
        access(32'h0000_0010, 4'h0, 32'h0, 1'b0);
        check("abort_unchanged", last_rd == 32'hDEAD_AAEF, last_rd, 32'hDEAD_AAEF);

        // access beyond the array: aliases to word 0 or flags an error
        access(32'h0000_0000, 4'hF, 32'hCAFE_0001, 1'b0);
        access(32'h0000_1000, 4'hF, 32'h0000_0055, 1'b0);
        idle(2);
        access(32'h0000_0000, 4'h0, 32'h0, 1'b0);
`ifdef VERMIBUS_RESPONDER_ERROR_EN
        check("oor_error_sticky", error == 1'b1, 32'(error), 32'h1);
        check("oor_no_write", last_rd == 32'hCAFE_0001, last_rd, 32'hCAFE_0001);
`else
        check("alias_error_low", error == 1'b0, 32'(error), 32'h0);
        check("alias_write", last_rd == 32'h0000_0055, last_rd, 32'h0000_0055);
`endif

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            logic [3:0]  s;
            bit          keep;
            a = 32'($urandom_range(0, 511));
            if ($urandom_range(0, 7) == 0) a[31:12] = 20'($urandom);
            s    = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            keep = (n != 149) && ($urandom_range(0, 2) == 0);
            access(a, s, $urandom, keep);
            if (!keep) idle($urandom_range(0, 2));
        end

        idle(5);
        check("scoreboard_empty", sb.size() == 0, 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
